// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches one word per cycle ahead of decode and redirects on branch, optionally keeping one delay slot.
// A pushed word appears at the head one cycle later; ROM waits hold the fetch address, and a full queue stalls fetch unless it also pops.
module fetch_queue #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                DELAY_SLOT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          rom_addr_o,
    output logic                       rom_en,
    input  logic [INST_W-1:0]          rom_inst_i,
    input  logic                       rom_ready_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [INST_W-1:0]          inst_o,
    input  logic                       branch_flag_i,
    input  logic [ADDR_W-1:0]          branch_addr_i,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  fpc;
    logic               redirect_pending;
    logic [ADDR_W-1:0]  redirect_tgt;

    logic               pop;
    logic               push;
    logic               keep_any;
    logic [ADDR_W-1:0]  tgt_new;
    logic [ADDR_W-1:0]  pend_tgt;
    logic [PTR_W-1:0]   rd_surv;
    entry_t             head;

    assign head         = mem[rd_ptr];
    assign inst_valid_o = !rst && (count != '0);
    assign pop          = inst_valid_o && inst_ready_i;
    assign rom_en       = !rst && ((count < CNT_W'(DEPTH)) || pop);
    assign push         = rom_en && rom_ready_i;
    assign rom_addr_o   = fpc;
    assign pc_o         = inst_valid_o ? head.pc : '0;
    assign inst_o       = inst_valid_o ? head.inst : '0;
    assign count_o      = rst ? '0 : count;

    assign tgt_new  = branch_addr_i & ~ADDR_W'(3);
    assign pend_tgt = branch_flag_i ? tgt_new : redirect_tgt;
    // Oldest entry that survives this cycle's pop; also where a push lands when the queue drains.
    assign rd_surv  = rd_ptr + PTR_W'(pop);
    assign keep_any = (count != CNT_W'(pop)) || push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: fpc, inst: rom_inst_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc              <= RESET_PC;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            redirect_pending <= 1'b0;
            redirect_tgt     <= '0;
        end else if (branch_flag_i && !redirect_pending) begin
            if (DELAY_SLOT == 0) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
                fpc    <= tgt_new;
            end else if (keep_any) begin
                rd_ptr <= rd_surv;
                wr_ptr <= rd_surv + PTR_W'(1);
                count  <= CNT_W'(1);
                fpc    <= tgt_new;
            end else begin
                // Nothing to serve as the delay slot yet: the next fetched word takes that role.
                redirect_pending <= 1'b1;
                redirect_tgt     <= tgt_new;
                rd_ptr           <= rd_surv;
                count            <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                fpc    <= redirect_pending ? pend_tgt : fpc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (redirect_pending) begin
                if (branch_flag_i) begin
                    redirect_tgt <= tgt_new;
                end
                if (push) begin
                    redirect_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default parameters): streaming, backpressure, ROM waits, redirects, reset.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_inst;
    logic        rom_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM returns its own address as the instruction word.
    assign rom_inst = rom_addr;

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .rom_addr_o   (rom_addr),
        .rom_en       (rom_en),
        .rom_inst_i   (rom_inst),
        .rom_ready_i  (rom_ready),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .pc_o         (pc),
        .inst_o       (inst),
        .branch_flag_i(branch_flag),
        .branch_addr_i(branch_addr),
        .count_o      (count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rom_ready = 1'b1; inst_ready = 1'b0;
        branch_flag = 1'b0; branch_addr = 32'h0;
        cyc(); cyc(); #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);

        // Streaming after reset release
        cyc(); rst = 1'b0; inst_ready = 1'b1; #1;
        chk("t1_en", 32'(rom_en), 32'h1);
        chk("t1_addr0", rom_addr, 32'h0);
        chk("t1_valid0", 32'(inst_valid), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            chk("t1_pc", pc, 32'((i - 1) * 4));
            chk("t1_inst", inst, 32'((i - 1) * 4));
            chk("t1_addr", rom_addr, 32'(i * 4));
            chk("t1_count", 32'(count), 32'h1);
        end

        // Fill and backpressure
        cyc(); inst_ready = 1'b0; #1;
        chk("t2_pc16", pc, 32'h10);
        cyc(); cyc(); cyc(); #1;
        chk("t2_full", 32'(count), 32'h4);
        chk("t2_en_off", 32'(rom_en), 32'h0);
        chk("t2_head", pc, 32'h10);
        cyc(); inst_ready = 1'b1; #1;
        chk("t2_en_pop", 32'(rom_en), 32'h1);
        chk("t2_addr_hold", rom_addr, 32'h20);
        cyc(); #1;
        chk("t2_count_same", 32'(count), 32'h4);
        chk("t2_pc20", pc, 32'h14);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("t2_order", pc, 32'(32'h18 + i * 4));
        end

        // ROM wait states
        cyc(); rst = 1'b1; rom_ready = 1'b1; inst_ready = 1'b0;
        cyc(); rst = 1'b0; #1;
        chk("t3_addr0", rom_addr, 32'h0);
        cyc(); rom_ready = 1'b0; #1;
        chk("t3_addr_r1", rom_addr, 32'h4);
        chk("t3_cnt_r1", 32'(count), 32'h1);
        cyc(); #1;
        chk("t3_addr_r2", rom_addr, 32'h4);
        chk("t3_en_r2", 32'(rom_en), 32'h1);
        cyc(); rom_ready = 1'b1; #1;
        chk("t3_addr_r3", rom_addr, 32'h4);
        cyc(); #1;
        chk("t3_addr_r4", rom_addr, 32'h8);
        chk("t3_cnt_r4", 32'(count), 32'h2);
        cyc(); rom_ready = 1'b0; inst_ready = 1'b1; #1;
        chk("t3_cnt_r5", 32'(count), 32'h3);
        chk("t3_pc0", pc, 32'h0);
        cyc(); #1;
        chk("t3_pc4", pc, 32'h4);
        cyc(); #1;
        chk("t3_pc8", pc, 32'h8);
        cyc(); #1;
        chk("t3_empty_valid", 32'(inst_valid), 32'h0);
        chk("t3_empty_pc", pc, 32'h0);
        chk("t3_empty_inst", inst, 32'h0);

        // Redirect with surviving entries: 0x14 stays as the delay slot
        cyc(); rst = 1'b1; rom_ready = 1'b1; inst_ready = 1'b1;
        cyc(); rst = 1'b0; #1;
        repeat (4) cyc();
        inst_ready = 1'b0; #1;
        chk("t4_pc12", pc, 32'hc);
        cyc(); inst_ready = 1'b1; #1;
        chk("t4_cnt2", 32'(count), 32'h2);
        cyc(); inst_ready = 1'b0; #1;
        chk("t4_pc16", pc, 32'h10);
        cyc(); rom_ready = 1'b0; inst_ready = 1'b1; branch_flag = 1'b1; branch_addr = 32'h100; #1;
        chk("t4_cnt3", 32'(count), 32'h3);
        chk("t4_head10", pc, 32'h10);
        cyc(); branch_flag = 1'b0; rom_ready = 1'b1; #1;
        chk("t4_cnt1", 32'(count), 32'h1);
        chk("t4_slot", pc, 32'h14);
        chk("t4_fetch_tgt", rom_addr, 32'h100);
        cyc(); #1;
        chk("t4_pc100", pc, 32'h100);
        cyc(); #1;
        chk("t4_pc104", pc, 32'h104);
        chk("t4_addr108", rom_addr, 32'h108);

        // Redirect with nothing left and ROM stalled: pending delay slot, misaligned target
        rom_ready = 1'b0; branch_flag = 1'b1; branch_addr = 32'h103;
        cyc(); branch_flag = 1'b0; #1;
        chk("t5_cnt0", 32'(count), 32'h0);
        chk("t5_en", 32'(rom_en), 32'h1);
        chk("t5_addr_seq", rom_addr, 32'h108);
        cyc(); inst_ready = 1'b0; #1;
        chk("t5_addr_hold", rom_addr, 32'h108);
        chk("t5_en2", 32'(rom_en), 32'h1);
        cyc(); rom_ready = 1'b1; #1;
        chk("t5_addr_slot", rom_addr, 32'h108);
        cyc(); #1;
        chk("t5_slot_cnt", 32'(count), 32'h1);
        chk("t5_slot_pc", pc, 32'h108);
        chk("t5_addr_tgt", rom_addr, 32'h100);
        cyc(); inst_ready = 1'b1; #1;
        chk("t5_cnt2", 32'(count), 32'h2);
        chk("t5_addr104", rom_addr, 32'h104);
        cyc(); inst_ready = 1'b0; #1;
        chk("t5_pc100", pc, 32'h100);

        // Mid-run reset with entries, then with a pending redirect
        cyc(); #1;
        chk("t6_cnt3", 32'(count), 32'h3);
        rst = 1'b1;
        cyc(); #1;
        chk("t6_rst_cnt", 32'(count), 32'h0);
        chk("t6_rst_valid", 32'(inst_valid), 32'h0);
        chk("t6_rst_en", 32'(rom_en), 32'h0);
        rst = 1'b0; rom_ready = 1'b0; inst_ready = 1'b1; branch_flag = 1'b1; branch_addr = 32'h200; #1;
        chk("t6_restart_addr", rom_addr, 32'h0);
        chk("t6_restart_en", 32'(rom_en), 32'h1);
        cyc(); branch_flag = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0; rom_ready = 1'b1; inst_ready = 1'b0; #1;
        chk("t6_addr0", rom_addr, 32'h0);
        cyc(); #1;
        chk("t6_head0", pc, 32'h0);
        chk("t6_valid", 32'(inst_valid), 32'h1);
        chk("t6_no_pending", rom_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
